// File: rtl/prim_alert_receiver_sync.sv
// prim_alert_receiver_sync: decodes the differential alert pair, completes the
// four-phase ack handshake, issues in-band pings and flags signal-integrity faults.
// alert_tx_i = {alert_p, alert_n}; alert_rx_o = {ping_p, ping_n, ack_p, ack_n}.
module prim_alert_receiver_sync #(
   parameter bit AsyncOn = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ping_en_i,
   input  logic [1:0] alert_tx_i,
   output logic [3:0] alert_rx_o,
   output logic       ping_ok_o,
   output logic       alert_o,
   output logic       integ_fail_o
);
   typedef enum logic [1:0] {Idle, HsAckWait, Pause0, Pause1} state_e;
   state_e     state_q;
   logic [1:0] sync1_q, sync2_q, pair;
   logic       eq, eq_q, sigint, level, level_q;
   logic       ping_q, ping_pend_q, ack_q, hs_start;
   // two-flop synchronizer, reset to the idle differential value to avoid a false fault
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 2'b01;
         sync2_q <= 2'b01;
      end else begin
         sync1_q <= alert_tx_i;
         sync2_q <= sync1_q;
      end
   end
   assign pair   = AsyncOn ? sync2_q : alert_tx_i;
   assign eq     = pair[1] == pair[0];
   assign sigint = AsyncOn ? (eq & eq_q) : eq;
   assign level  = eq ? level_q : pair[1];
   // decoder history: last valid level and whether the previous sample was non-differential
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         level_q <= level;
         eq_q    <= eq;
      end
   end
   assign hs_start     = ~rst_i & (state_q == Idle) & level & ~sigint;
   assign ping_ok_o    = hs_start & ping_pend_q;
   assign alert_o      = hs_start & ~ping_pend_q;
   assign integ_fail_o = ~rst_i & sigint;
   // ping launch: toggle only when no ping is outstanding; pending survives integrity faults
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ping_q      <= 1'b0;
         ping_pend_q <= 1'b0;
      end else begin
         ping_q      <= ping_q ^ (ping_en_i & ~ping_pend_q);
         ping_pend_q <= ~ping_ok_o & (ping_pend_q | ping_en_i);
      end
   end
   // handshake FSM with registered ack; an integrity fault forces Idle with ack low
   always_ff @(posedge clk_i) begin
      if (rst_i || sigint) begin
         state_q <= Idle;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            Idle: if (level) begin
               state_q <= HsAckWait;
               ack_q   <= 1'b1;
            end
            HsAckWait: if (!level) begin
               state_q <= Pause0;
               ack_q   <= 1'b0;
            end
            Pause0: state_q <= Pause1;
            Pause1: state_q <= Idle;
            default: begin
               state_q <= Idle;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end
   assign alert_rx_o = {ping_q, ~ping_q, ack_q, ~ack_q};
endmodule

// File: tb/tb_prim_alert_receiver_sync.sv
// tb_prim_alert_receiver_sync: directed checks of a direct-sampled and a synchronized receiver.
module tb_prim_alert_receiver_sync;
   logic       clk_i = 1'b0, rst_i;
   logic       pe0, pe1, pok0, pok1, al0, al1, if0, if1;
   logic [1:0] tx0, tx1;
   logic [3:0] rx0, rx1;
   int         n_cmp = 0, n_bad = 0;
   int         n_al, n_rise, gap, min_gap;
   logic       prev_ack;
   bit         seen;

   prim_alert_receiver_sync #(.AsyncOn(1'b0)) u0 (
      .clk_i(clk_i), .rst_i(rst_i), .ping_en_i(pe0), .alert_tx_i(tx0),
      .alert_rx_o(rx0), .ping_ok_o(pok0), .alert_o(al0), .integ_fail_o(if0));
   prim_alert_receiver_sync #(.AsyncOn(1'b1)) u1 (
      .clk_i(clk_i), .rst_i(rst_i), .ping_en_i(pe1), .alert_tx_i(tx1),
      .alert_rx_o(rx1), .ping_ok_o(pok1), .alert_o(al1), .integ_fail_o(if1));

   // free-running clock, period 10
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      rst_i = 1'b1; pe0 = 1'b0; pe1 = 1'b0; tx0 = 2'b01; tx1 = 2'b01;
      cyc(2);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_rx0", rx0, 4'b0101); chk("rst_rx1", rx1, 4'b0101);
      chk("rst_al0", al0, 0); chk("rst_pok0", pok0, 0); chk("rst_if0", if0, 0);
      chk("rst_al1", al1, 0); chk("rst_if1", if1, 0);
      // basic alert handshake and back-to-back re-rise
      cyc(); tx0 = 2'b10;
      @(negedge clk_i); chk("a0_al", al0, 1); chk("a0_pok", pok0, 0); chk("a0_rx", rx0, 4'b0101);
      cyc(); @(negedge clk_i); chk("a1_al", al0, 0); chk("a1_rx", rx0, 4'b0110);
      cyc(2); @(negedge clk_i); chk("a3_rx", rx0, 4'b0110);
      cyc(); tx0 = 2'b01; @(negedge clk_i); chk("a4_rx", rx0, 4'b0110);
      cyc(); tx0 = 2'b10; @(negedge clk_i); chk("a5_rx", rx0, 4'b0101); chk("a5_al", al0, 0);
      cyc(); @(negedge clk_i); chk("a6_al", al0, 0); chk("a6_rx", rx0, 4'b0101);
      cyc(); @(negedge clk_i); chk("a7_al", al0, 1);
      cyc(); @(negedge clk_i); chk("a8_rx", rx0, 4'b0110); chk("a8_al", al0, 0);
      cyc(); tx0 = 2'b01; cyc(4);
      // integrity fault during HsAckWait with a pending ping
      tx0 = 2'b10; @(negedge clk_i); chk("c0_al", al0, 1);
      cyc(); pe0 = 1'b1; @(negedge clk_i); chk("c1_rx", rx0, 4'b0110);
      cyc(); pe0 = 1'b0; @(negedge clk_i); chk("c2_rx", rx0, 4'b1010);
      cyc(); tx0 = 2'b11; @(negedge clk_i);
      chk("c3_if", if0, 1); chk("c3_pok", pok0, 0); chk("c3_al", al0, 0); chk("c3_rx", rx0, 4'b1010);
      cyc(); @(negedge clk_i); chk("c4_if", if0, 1); chk("c4_rx", rx0, 4'b1001);
      cyc(); @(negedge clk_i); chk("c5_if", if0, 1);
      cyc(); tx0 = 2'b10; @(negedge clk_i); chk("c6_if", if0, 0); chk("c6_pok", pok0, 1); chk("c6_al", al0, 0);
      cyc(); tx0 = 2'b01; @(negedge clk_i); chk("c7_pok", pok0, 0); chk("c7_rx", rx0, 4'b1010);
      cyc(4);
      // ping pending was cleared, so a new request toggles; then consume it
      pe0 = 1'b1; cyc(); pe0 = 1'b0; @(negedge clk_i); chk("p1_rx", rx0, 4'b0101);
      cyc(); tx0 = 2'b10; @(negedge clk_i); chk("q0_pok", pok0, 1); chk("q0_al", al0, 0);
      cyc(); tx0 = 2'b01; cyc(4);
      // synchronized receiver: ping round trip, second request ignored
      pe1 = 1'b1; @(negedge clk_i); chk("b0_rx", rx1, 4'b0101);
      cyc(); pe1 = 1'b0; @(negedge clk_i); chk("b1_rx", rx1, 4'b1001);
      cyc(); pe1 = 1'b1; @(negedge clk_i); chk("b2_rx", rx1, 4'b1001);
      cyc(); pe1 = 1'b0; tx1 = 2'b10; @(negedge clk_i); chk("b3_pok", pok1, 0); chk("b3_rx", rx1, 4'b1001);
      cyc(); @(negedge clk_i); chk("b4_pok", pok1, 0);
      cyc(); @(negedge clk_i); chk("b5_pok", pok1, 1); chk("b5_al", al1, 0);
      cyc(); @(negedge clk_i); chk("b6_pok", pok1, 0); chk("b6_rx", rx1, 4'b1010);
      tx1 = 2'b01; cyc(6);
      // single skewed sample is tolerated
      tx1 = 2'b11; cyc(); tx1 = 2'b10;
      cyc(); @(negedge clk_i); chk("s2_if", if1, 0); chk("s2_al", al1, 0); chk("s2_pok", pok1, 0);
      cyc(); @(negedge clk_i); chk("s3_al", al1, 1); chk("s3_if", if1, 0);
      tx1 = 2'b01; cyc(6);
      // two equal samples raise the fault on the second
      tx1 = 2'b00; cyc(); cyc(); tx1 = 2'b01;
      @(negedge clk_i); chk("t2_if", if1, 0);
      cyc(); @(negedge clk_i); chk("t3_if", if1, 1); chk("t3_al", al1, 0);
      cyc(); @(negedge clk_i); chk("t4_if", if1, 0);
      // continuous alert from a sender that answers ack immediately
      n_al = 0; n_rise = 0; gap = 0; min_gap = 99; prev_ack = 1'b0; seen = 1'b0;
      cyc();
      for (int i = 0; i < 30; i++) begin
         tx0 = rx0[1] ? 2'b01 : 2'b10;
         @(negedge clk_i);
         n_al += int'(al0);
         if (rx0[1] && !prev_ack) begin
            n_rise++;
            if (seen && gap < min_gap) min_gap = gap;
            seen = 1'b1;
         end
         gap = rx0[1] ? 0 : gap + 1;
         prev_ack = rx0[1];
         cyc();
      end
      chk("cont_alerts", n_al, 8); chk("cont_rises", n_rise, 8); chk("cont_min_gap", min_gap, 3);
      tx0 = 2'b01; cyc(5);
      // reset asserted in HsAckWait with a ping pending
      tx0 = 2'b10; @(negedge clk_i); chk("r0_al", al0, 1);
      cyc(); pe0 = 1'b1; @(negedge clk_i); chk("r1_rx", rx0, 4'b0110);
      cyc(); pe0 = 1'b0; rst_i = 1'b1; @(negedge clk_i); chk("r2_al", al0, 0); chk("r2_pok", pok0, 0);
      cyc(); @(negedge clk_i); chk("r3_rx", rx0, 4'b0101); chk("r3_al", al0, 0); chk("r3_pok", pok0, 0);
      cyc(); rst_i = 1'b0; tx0 = 2'b01; pe0 = 1'b1; @(negedge clk_i); chk("r4_rx", rx0, 4'b0101);
      cyc(); pe0 = 1'b0; @(negedge clk_i); chk("r5_rx", rx0, 4'b1001);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/prim_alert_receiver_sync.md
Name: prim_alert_receiver_sync

Overview:
Receiving end of the differential alert protocol. It decodes the alert_p/n pair driven by an alert sender and completes the four-phase handshake on ack_p/n. It originates in-band pings by toggling ping_p/n, and reports alerts, ping responses and signal-integrity faults to the alert handler. One instance sits per alert channel inside the alert handler.

Parameters:
AsyncOn, 1'b1, 1 = alert_p/n pass through a 2-flop synchronizer before decode and sigint needs 2 consecutive equal samples; 0 = sampled directly, sigint on 1 sample.

Ports:
clk_i  input  1  clock; one clock.
rst_i  input  1  reset, synchronous and active-high.
ping_en_i  input  1  single-cycle request to issue a ping.
alert_tx_i  input  alert_tx_t (2)  alert_p/alert_n diff pair from sender.
alert_rx_o  output  alert_rx_t (4)  ping_p/ping_n/ack_p/ack_n diff pairs to sender.
ping_ok_o  output  1  1-cycle pulse: handshake answered a pending ping.
alert_o  output  1  1-cycle pulse: handshake was a genuine alert.
integ_fail_o  output  1  high every cycle the alert pair is non-differential.

Behaviour:
- Reset values: ping_p=0, ping_n=1, ack_p=0, ack_n=1, ping_ok_o=0, alert_o=0, integ_fail_o=0, state=Idle, ping_pend=0, decoder level=0.
- ping_p/n, ack_p/n: registered and always complementary. Reset mid-operation returns everything to reset values on the next edge.
- Decode:
  - p!=n: level=p, sigint=0.
  - p==n, AsyncOn=0: sigint=1, level holds.
  - p==n, AsyncOn=1: first equal sample holds level with sigint=0 (skew tolerance); second and later consecutive equal samples give sigint=1.
- Decode latency from pin to decoded level: 0 cycles when AsyncOn=0, 2 cycles when AsyncOn=1.
- Ping:
  - ping_en_i=1 and ping_pend=0: ping_p/n toggle next edge and ping_pend sets.
  - ping_en_i while ping_pend=1: ignored, no toggle.
  - ping_pend clears in the cycle ping_ok_o pulses. It is retained across sigint.
- FSM: Idle, HsAckWait, Pause0, Pause1.
  - Idle: if level=1, go to HsAckWait and set ack_p=1 next edge. In the same cycle, pulse ping_ok_o if ping_pend=1, else pulse alert_o. The pulses are combinational, one cycle only.
  - HsAckWait: ack held 1 while level=1; when level=0, ack=0 next edge, go to Pause0.
  - Pause0 -> Pause1 -> Idle, unconditionally. level=1 during a pause is serviced on return to Idle.
  - Illegal encodings go to Idle.
- Sigint overrides every state: integ_fail_o=1 (combinational), next state Idle, ack driven 0, no ping_ok_o/alert_o pulse that cycle. Toggling p==n pairs keep integ_fail_o high continuously.
- ping_en_i in the same Idle cycle as a handshake start: ping_pend is not yet set, so the handshake is classed as alert_o; the ping stays pending.
- Back-to-back alerts, with level re-rising immediately after dropping: at least 3 cycles between ack falling and ack rising again (Pause0, Pause1, Idle).
- Per-handshake classification: exactly one of ping_ok_o/alert_o pulses per handshake.

Test Plan:
- Reset, AsyncOn=0: hold rst_i=1 for 2 cycles, then release -> ping_p=0, ping_n=1, ack_p=0, ack_n=1, all pulses 0. Drive alert_p=1/n=0 at cycle 10 -> alert_o=1 in cycle 10 only; ack_p=1 from cycle 11. Drop alert at 14 -> ack_p=0 at 15; state back to Idle by 17.
- Ping round-trip, AsyncOn=1: ping_en_i pulse at cycle 5 -> ping_p toggles 0->1 at 6. Sender answers with alert_p=1 at 8 -> ping_ok_o=1 at cycle 10, alert_o stays 0, ping_pend clears. A second ping_en_i at 7 produces no toggle.
- Sigint: drive alert_p=alert_n=1 for 3 cycles during HsAckWait with AsyncOn=0 -> integ_fail_o=1 for those 3 cycles, ack_p=0 after the first, state=Idle. A pending ping survives and completes afterward with a ping_ok_o pulse.
- AsyncOn=1 skew: one cycle of p==n mid-transition -> integ_fail_o stays 0, no spurious pulse. Two cycles of p==n -> integ_fail_o=1 on the second synchronized sample.
- Continuous alert held for 30 cycles -> repeated handshakes, each giving exactly one alert_o pulse, ack low for at least 3 cycles between them.
- Assert rst_i in HsAckWait -> next edge ack_p=0, ack_n=1, ping_pend=0, no pulses.
